mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Sequences and shares the single data-memory port (DPI pmem_read/pmem_write datapath) between
//   instruction fetch (IFU) and load/store unit (LSU). Accepts one request at a time via valid/ready,
//   drives the memory port enable for exactly one cycle per access (no duplicate DPI writes),
//   models a configurable access latency, and returns the result via a resp valid/ready handshake.
// PARAMETERS
//   MEM_LATENCY  1   cycles from ACCESS cycle to first RESP cycle; legal range 1..15
//   IFU_CTRL     4'b0101  ctrl code driven for fetches (4-byte, zero-extended load)
// PORTS
//   clk             in   1   sole clock, rising edge
//   rst_n           in   1   asynchronous, active-low reset
//   ifu_req_valid   in   1   IFU fetch request
//   ifu_req_ready   out  1   IFU request accepted this cycle when valid&&ready
//   ifu_addr        in   64  fetch address
//   ifu_resp_valid  out  1   fetch data valid
//   ifu_resp_ready  in   1   IFU consumes response
//   ifu_rdata       out  64  fetched data
//   lsu_req_valid   in   1   LSU request
//   lsu_req_ready   out  1   LSU request accepted when valid&&ready
//   lsu_addr        in   64  load/store address
//   lsu_wdata       in   64  store data
//   lsu_ctrl        in   4   access code; bit3=1 store, bit3=0 load
//   lsu_resp_valid  out  1   load data / store ack valid
//   lsu_resp_ready  in   1   LSU consumes response
//   lsu_rdata       out  64  load data (0 for stores)
//   mem_en          out  1   memory port enable
//   mem_addr        out  64  memory port address
//   mem_wdata       out  64  memory port write data
//   mem_ctrl        out  4   memory port access code
//   mem_rdata       in   64  memory port read data (combinational from port)
// BEHAVIOUR
//   Reset: state=IDLE; all *_ready, *_resp_valid, mem_en = 0; mem_addr/wdata/ctrl, *_rdata = 0; cnt=0.
//   FSM IDLE -> ACCESS -> WAIT -> RESP -> IDLE.
//   IDLE: *_req_ready=1 only for the granted requester (combinational from valids); other ready=0.
//     Grant: LSU wins when both valid (fixed priority). On handshake latch addr/wdata/ctrl/owner
//     (IFU: ctrl=IFU_CTRL, wdata=0) -> ACCESS. No valid: stay IDLE.
//   ACCESS (exactly 1 cycle): mem_en=1, mem_* = latched values; capture mem_rdata at edge
//     (stores capture 0); cnt<=MEM_LATENCY-1; -> WAIT if cnt load >0 else RESP.
//   WAIT: mem_en=0; cnt decrements; -> RESP when cnt==1 (sits MEM_LATENCY-1 cycles).
//   RESP: owner's resp_valid=1, rdata=captured value, held stable until owner resp_ready=1;
//     on that edge -> IDLE. Non-owner resp_valid=0. Both req_ready=0 outside IDLE.
//   Latency: accept edge T; mem_en high in T+1; resp_valid first high T+1+MEM_LATENCY.
//   Throughput: back-to-back requests need a fresh IDLE cycle (max 1 access per MEM_LATENCY+2 cycles).
//   mem_en=0 drives mem_addr/wdata/ctrl to 0 (no DPI call outside ACCESS).
//   Request valid dropping before grant: allowed, no side effect. Ctrl codes passed unmodified.
//   Reset mid-operation: immediate return to IDLE, transaction discarded, no response; a store
//     whose ACCESS cycle already occurred stays committed.
// CONFIGURATION
//   MEM_ARB_RR_EN defined: round-robin; 1-bit last_grant (reset = IFU) updates on each accept;
//     on simultaneous valid the requester not last granted wins. First conflict after reset -> LSU.
//   MEM_ARB_RR_EN undefined: fixed LSU priority, no last_grant state; IFU may starve.
//   Single requester behaviour identical in both builds.
// TESTING
//   1 IFU req addr=0x80000000, MEM_LATENCY=1, mem_rdata=0x00000413 -> mem_en 1 cycle at T+1,
//     ifu_resp_valid at T+2, ifu_rdata=0x00000413.
//   2 LSU store ctrl=4'b1000 addr=0x80001000 wdata=0xDEADBEEF, resp_ready low 3 cycles -> mem_en
//     exactly 1 cycle, lsu_resp_valid held 3+ cycles, lsu_rdata=0, no second write.
//   3 Both valid continuously for 4 accepts -> fixed: LSU,LSU,LSU,LSU; RR_EN: LSU,IFU,LSU,IFU.
//   4 MEM_LATENCY=4, LSU load -> resp_valid first at T+5; req_ready both 0 from T+1 until return to IDLE.
//   5 rst_n low during WAIT -> same cycle all outputs 0, state IDLE, no resp after release;
//     next IFU req completes normally.
//   6 IFU valid asserted then dropped before grant while LSU busy -> no fetch issued, mem_en stays 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and the load/store unit; one access in flight.
// Optional build macro MEM_ARB_RR_EN selects round-robin arbitration instead of fixed LSU priority.
module mem_arbiter #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter logic [3:0]  IFU_CTRL    = 4'b0101
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [63:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [63:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [63:0] lsu_addr,
  input  logic [63:0] lsu_wdata,
  input  logic [3:0]  lsu_ctrl,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [63:0] lsu_rdata,
  output logic        mem_en,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [3:0]  mem_ctrl,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic        owner_lsu_r;
  logic [63:0] data_r;
  logic        grant_lsu_s;
  logic        grant_ifu_s;
  logic [63:0] cap_s;

`ifdef MEM_ARB_RR_EN
  logic        last_grant_lsu_r;

  // Remember who won the most recent accept so a conflict goes to the other side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_lsu_r <= 1'b0;
    end else if (grant_lsu_s) begin
      last_grant_lsu_r <= 1'b1;
    end else if (grant_ifu_s) begin
      last_grant_lsu_r <= 1'b0;
    end else begin
      last_grant_lsu_r <= last_grant_lsu_r;
    end
  end
`endif

  // Grant decision; ready is only offered in IDLE and never while reset is asserted.
  always_comb begin
    grant_lsu_s = 1'b0;
    grant_ifu_s = 1'b0;
    if (rst_n && (state_r == IDLE)) begin
`ifdef MEM_ARB_RR_EN
      if (lsu_req_valid && (!ifu_req_valid || !last_grant_lsu_r)) begin
        grant_lsu_s = 1'b1;
      end else if (ifu_req_valid) begin
        grant_ifu_s = 1'b1;
      end else begin
        grant_lsu_s = 1'b0;
      end
`else
      if (lsu_req_valid) begin
        grant_lsu_s = 1'b1;
      end else if (ifu_req_valid) begin
        grant_ifu_s = 1'b1;
      end else begin
        grant_lsu_s = 1'b0;
      end
`endif
    end else begin
      grant_ifu_s = 1'b0;
    end
    ifu_req_ready = grant_ifu_s;
    lsu_req_ready = grant_lsu_s;
    cap_s = mem_ctrl[3] ? 64'd0 : mem_rdata;
  end

  // Access sequencer: port is driven only in ACCESS, so each request makes exactly one memory call.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      cnt_r          <= 4'd0;
      owner_lsu_r    <= 1'b0;
      data_r         <= 64'd0;
      mem_en         <= 1'b0;
      mem_addr       <= 64'd0;
      mem_wdata      <= 64'd0;
      mem_ctrl       <= 4'd0;
      ifu_resp_valid <= 1'b0;
      ifu_rdata      <= 64'd0;
      lsu_resp_valid <= 1'b0;
      lsu_rdata      <= 64'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_lsu_s) begin
            mem_en      <= 1'b1;
            mem_addr    <= lsu_addr;
            mem_wdata   <= lsu_wdata;
            mem_ctrl    <= lsu_ctrl;
            owner_lsu_r <= 1'b1;
            state_r     <= ACCESS;
          end else if (grant_ifu_s) begin
            mem_en      <= 1'b1;
            mem_addr    <= ifu_addr;
            mem_wdata   <= 64'd0;
            mem_ctrl    <= IFU_CTRL;
            owner_lsu_r <= 1'b0;
            state_r     <= ACCESS;
          end else begin
            state_r     <= IDLE;
          end
        end
        ACCESS: begin
          mem_en    <= 1'b0;
          mem_addr  <= 64'd0;
          mem_wdata <= 64'd0;
          mem_ctrl  <= 4'd0;
          data_r    <= cap_s;
          cnt_r     <= LAT_M1;
          if (LAT_M1 != 4'd0) begin
            state_r <= WAIT;
          end else begin
            state_r <= RESP;
            if (owner_lsu_r) begin
              lsu_resp_valid <= 1'b1;
              lsu_rdata      <= cap_s;
            end else begin
              ifu_resp_valid <= 1'b1;
              ifu_rdata      <= cap_s;
            end
          end
        end
        WAIT: begin
          if (cnt_r == 4'd1) begin
            cnt_r   <= 4'd0;
            state_r <= RESP;
            if (owner_lsu_r) begin
              lsu_resp_valid <= 1'b1;
              lsu_rdata      <= data_r;
            end else begin
              ifu_resp_valid <= 1'b1;
              ifu_rdata      <= data_r;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          if (owner_lsu_r ? lsu_resp_ready : ifu_resp_ready) begin
            ifu_resp_valid <= 1'b0;
            ifu_rdata      <= 64'd0;
            lsu_resp_valid <= 1'b0;
            lsu_rdata      <= 64'd0;
            state_r        <= IDLE;
          end else begin
            state_r        <= RESP;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: two instances (latency 1 and 4) against a transaction-level model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid [2];
  logic        ifu_req_ready [2];
  logic [63:0] ifu_addr      [2];
  logic        ifu_resp_valid[2];
  logic        ifu_resp_ready[2];
  logic [63:0] ifu_rdata     [2];
  logic        lsu_req_valid [2];
  logic        lsu_req_ready [2];
  logic [63:0] lsu_addr      [2];
  logic [63:0] lsu_wdata     [2];
  logic [3:0]  lsu_ctrl      [2];
  logic        lsu_resp_valid[2];
  logic        lsu_resp_ready[2];
  logic [63:0] lsu_rdata     [2];
  logic        mem_en        [2];
  logic [63:0] mem_addr      [2];
  logic [63:0] mem_wdata     [2];
  logic [3:0]  mem_ctrl      [2];
  logic [63:0] mem_rdata     [2];

  int n_cmp = 0;
  int n_bad = 0;
  int en_cnt[2] = '{0, 0};
  int wr_cnt[2] = '{0, 0};
  bit last_lsu[2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  // Memory contents as a pure function of address.
  function automatic logic [63:0] memf(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 64'h0000_0000_0000_0413;
    return {a[31:0] ^ 32'h5A5A_C3C3, ~a[31:0]};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.MEM_LATENCY(g == 0 ? 1 : 4), .IFU_CTRL(4'b0101)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .ifu_req_valid(ifu_req_valid[g]), .ifu_req_ready(ifu_req_ready[g]), .ifu_addr(ifu_addr[g]),
      .ifu_resp_valid(ifu_resp_valid[g]), .ifu_resp_ready(ifu_resp_ready[g]), .ifu_rdata(ifu_rdata[g]),
      .lsu_req_valid(lsu_req_valid[g]), .lsu_req_ready(lsu_req_ready[g]), .lsu_addr(lsu_addr[g]),
      .lsu_wdata(lsu_wdata[g]), .lsu_ctrl(lsu_ctrl[g]),
      .lsu_resp_valid(lsu_resp_valid[g]), .lsu_resp_ready(lsu_resp_ready[g]), .lsu_rdata(lsu_rdata[g]),
      .mem_en(mem_en[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_ctrl(mem_ctrl[g]),
      .mem_rdata(mem_rdata[g])
    );
    assign mem_rdata[g] = memf(mem_addr[g]);
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_en[i] === 1'b1) begin
        en_cnt[i] <= en_cnt[i] + 1;
        if (mem_ctrl[i][3] === 1'b1) wr_cnt[i] <= wr_cnt[i] + 1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle_outputs(input int k, input string tag);
    chkb({tag, "_ifu_ready"}, ifu_req_ready[k], 1'b0);
    chkb({tag, "_lsu_ready"}, lsu_req_ready[k], 1'b0);
    chkb({tag, "_ifu_rv"}, ifu_resp_valid[k], 1'b0);
    chkb({tag, "_lsu_rv"}, lsu_resp_valid[k], 1'b0);
    chk({tag, "_ifu_rdata"}, ifu_rdata[k], 64'd0);
    chk({tag, "_lsu_rdata"}, lsu_rdata[k], 64'd0);
    chkb({tag, "_mem_en"}, mem_en[k], 1'b0);
    chk({tag, "_mem_addr"}, mem_addr[k], 64'd0);
    chk({tag, "_mem_wdata"}, mem_wdata[k], 64'd0);
    chk({tag, "_mem_ctrl"}, {60'd0, mem_ctrl[k]}, 64'd0);
  endtask

  // One full transaction from IDLE; other requester kept valid while busy to prove it is held off.
  task automatic do_txn(input int k, input bit vi, input bit vl, input logic [63:0] ai,
                        input logic [63:0] al, input logic [63:0] wd, input logic [3:0] ctl,
                        input int d, output bit got_lsu);
    int lat;
    bit exp_lsu;
    logic [63:0] ea, ew, erd;
    logic [3:0] ec;
    int en0, wr0;
    lat = (k == 0) ? 1 : 4;
    @(negedge clk);
    ifu_req_valid[k] = vi; lsu_req_valid[k] = vl;
    ifu_addr[k] = ai; lsu_addr[k] = al; lsu_wdata[k] = wd; lsu_ctrl[k] = ctl;
    #1;
`ifdef MEM_ARB_RR_EN
    exp_lsu = vl && (!vi || !last_lsu[k]);
`else
    exp_lsu = vl;
`endif
    chkb("grant_lsu_ready", lsu_req_ready[k], exp_lsu);
    chkb("grant_ifu_ready", ifu_req_ready[k], vi && !exp_lsu);
    got_lsu = lsu_req_ready[k];
    last_lsu[k] = exp_lsu;
    ea = exp_lsu ? al : ai;
    ew = exp_lsu ? wd : 64'd0;
    ec = exp_lsu ? ctl : 4'b0101;
    erd = ec[3] ? 64'd0 : memf(ea);
    en0 = en_cnt[k];
    wr0 = wr_cnt[k];
    @(posedge clk);
    for (int c = 1; c <= lat + 1 + d; c++) begin
      @(negedge clk);
      if (c == lat + 1 + d) begin
        ifu_req_valid[k] = 1'b0; lsu_req_valid[k] = 1'b0;
        if (exp_lsu) lsu_resp_ready[k] = 1'b1; else ifu_resp_ready[k] = 1'b1;
      end else begin
        ifu_req_valid[k] = 1'b1; lsu_req_valid[k] = 1'b1;
        ifu_addr[k] = {$urandom, $urandom}; lsu_addr[k] = {$urandom, $urandom};
      end
      #1;
      chkb("mem_en", mem_en[k], c == 1);
      chk("mem_addr", mem_addr[k], (c == 1) ? ea : 64'd0);
      chk("mem_wdata", mem_wdata[k], (c == 1) ? ew : 64'd0);
      chk("mem_ctrl", {60'd0, mem_ctrl[k]}, (c == 1) ? {60'd0, ec} : 64'd0);
      chkb("busy_ifu_ready", ifu_req_ready[k], 1'b0);
      chkb("busy_lsu_ready", lsu_req_ready[k], 1'b0);
      if (exp_lsu) begin
        chkb("lsu_resp_valid", lsu_resp_valid[k], c >= lat + 1);
        chkb("ifu_resp_valid_nonowner", ifu_resp_valid[k], 1'b0);
        if (c >= lat + 1) chk("lsu_rdata", lsu_rdata[k], erd);
      end else begin
        chkb("ifu_resp_valid", ifu_resp_valid[k], c >= lat + 1);
        chkb("lsu_resp_valid_nonowner", lsu_resp_valid[k], 1'b0);
        if (c >= lat + 1) chk("ifu_rdata", ifu_rdata[k], erd);
      end
      @(posedge clk);
    end
    @(negedge clk);
    ifu_resp_ready[k] = 1'b0; lsu_resp_ready[k] = 1'b0;
    #1;
    chkb("post_ifu_rv", ifu_resp_valid[k], 1'b0);
    chkb("post_lsu_rv", lsu_resp_valid[k], 1'b0);
    chk("mem_en_count", 64'(en_cnt[k] - en0), 64'd1);
    chk("write_count", 64'(wr_cnt[k] - wr0), ec[3] ? 64'd1 : 64'd0);
  endtask

  initial begin
    bit got;
    bit pat[4];
    bit vi, vl;
`ifdef MEM_ARB_RR_EN
    pat = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    pat = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ifu_req_valid[i] = 1'b0; ifu_addr[i] = 64'd0; ifu_resp_ready[i] = 1'b0;
      lsu_req_valid[i] = 1'b0; lsu_addr[i] = 64'd0; lsu_wdata[i] = 64'd0;
      lsu_ctrl[i] = 4'd0; lsu_resp_ready[i] = 1'b0;
    end
    #1;
    idle_outputs(0, "reset0");
    idle_outputs(1, "reset1");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fetch at latency 1, then a back-pressured store.
    do_txn(0, 1'b1, 1'b0, 64'h8000_0000, 64'd0, 64'd0, 4'd0, 0, got);
    do_txn(0, 1'b0, 1'b1, 64'd0, 64'h8000_1000, 64'hDEAD_BEEF, 4'b1000, 3, got);
    // Latency-4 load.
    do_txn(1, 1'b0, 1'b1, 64'd0, 64'h8000_2468, 64'd0, 4'b0011, 0, got);

    // Reset while waiting on the latency-4 instance.
    @(negedge clk);
    lsu_req_valid[1] = 1'b1; lsu_addr[1] = 64'h8000_3000; lsu_ctrl[1] = 4'b0011;
    @(posedge clk);
    @(negedge clk);
    lsu_req_valid[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    lsu_req_valid[1] = 1'b1;
    #1;
    idle_outputs(1, "rst_wait");
    @(negedge clk);
    rst_n = 1'b1;
    lsu_req_valid[1] = 1'b0;
    last_lsu = '{1'b0, 1'b0};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      idle_outputs(1, "after_rst");
    end
    do_txn(1, 1'b1, 1'b0, 64'h8000_0040, 64'd0, 64'd0, 4'd0, 1, got);

    // Both requesters continuously valid.
    for (int i = 0; i < 4; i++) begin
      do_txn(0, 1'b1, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             4'($urandom_range(0, 15)), int'($urandom_range(0, 1)), got);
      chkb("conflict_order", got, pat[i]);
    end

    // Randomized traffic on both instances.
    for (int n = 0; n < 24; n++) begin
      vi = 1'($urandom_range(0, 1));
      vl = vi ? 1'($urandom_range(0, 1)) : 1'b1;
      do_txn(n % 2, vi, vl, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             4'($urandom_range(0, 15)), int'($urandom_range(0, 2)), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
